// File: rtl/td4p_core.sv
// td4p_core: parametrised TD4-style CPU core. One instruction retires per cycle when
// the fetch is valid: dst <- src + Im. Adds a fetch stall, an OUT write strobe, JC, HALT and NOP.
module td4p_core #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W+3:0] imem_rdata,
   input  logic              imem_valid,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic              out_we,
   output logic              carry,
   output logic              halted
);

   generate
      if (DATA_W < 4 || ADDR_W > DATA_W || ADDR_W < 1) begin : g_bad_params
         $error("td4p_core: need DATA_W >= 4 and 1 <= ADDR_W <= DATA_W");
      end
   endgenerate

   localparam logic [3:0] OP_ADD_A  = 4'b0000;
   localparam logic [3:0] OP_MOV_AB = 4'b0001;
   localparam logic [3:0] OP_IN_A   = 4'b0010;
   localparam logic [3:0] OP_MOV_AI = 4'b0011;
   localparam logic [3:0] OP_MOV_BA = 4'b0100;
   localparam logic [3:0] OP_ADD_B  = 4'b0101;
   localparam logic [3:0] OP_IN_B   = 4'b0110;
   localparam logic [3:0] OP_MOV_BI = 4'b0111;
   localparam logic [3:0] OP_OUT_A  = 4'b1000;
   localparam logic [3:0] OP_OUT_B  = 4'b1001;
   localparam logic [3:0] OP_JC     = 4'b1010;
   localparam logic [3:0] OP_OUT_I  = 4'b1011;
   localparam logic [3:0] OP_HALT   = 4'b1100;
   localparam logic [3:0] OP_NOP    = 4'b1101;
   localparam logic [3:0] OP_JNC    = 4'b1110;
   localparam logic [3:0] OP_JMP    = 4'b1111;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] reg_a;
   logic [DATA_W-1:0] reg_b;

   logic [3:0]        opcode;
   logic [DATA_W-1:0] imm;
   logic [ADDR_W-1:0] jump_target;
   logic [DATA_W-1:0] src;
   logic [DATA_W:0]   sum;
   logic              retire;
   logic              wr_a;
   logic              wr_b;
   logic              wr_out;
   logic              uses_adder;
   logic              take_jump;
   logic              do_halt;

   assign opcode      = imem_rdata[DATA_W+3:DATA_W];
   assign imm         = imem_rdata[DATA_W-1:0];
   assign jump_target = imm[ADDR_W-1:0];
   assign imem_addr   = pc;
   assign halted      = (state == ST_HALT);
   assign retire      = (state == ST_RUN) && imem_valid;

   // Decode: pick the adder source and the destination. Immediate moves add to zero.
   always_comb begin
      src        = '0;
      wr_a       = 1'b0;
      wr_b       = 1'b0;
      wr_out     = 1'b0;
      uses_adder = 1'b1;
      take_jump  = 1'b0;
      do_halt    = 1'b0;
      case (opcode)
         OP_ADD_A:  begin src = reg_a;   wr_a = 1'b1; end
         OP_MOV_AB: begin src = reg_b;   wr_a = 1'b1; end
         OP_IN_A:   begin src = in_port; wr_a = 1'b1; end
         OP_MOV_AI: wr_a = 1'b1;
         OP_MOV_BA: begin src = reg_a;   wr_b = 1'b1; end
         OP_ADD_B:  begin src = reg_b;   wr_b = 1'b1; end
         OP_IN_B:   begin src = in_port; wr_b = 1'b1; end
         OP_MOV_BI: wr_b = 1'b1;
         OP_OUT_A:  begin src = reg_a;   wr_out = 1'b1; end
         OP_OUT_B:  begin src = reg_b;   wr_out = 1'b1; end
         OP_OUT_I:  wr_out = 1'b1;
         OP_JC:     begin uses_adder = 1'b0; take_jump = carry;  end
         OP_JNC:    begin uses_adder = 1'b0; take_jump = !carry; end
         OP_JMP:    begin uses_adder = 1'b0; take_jump = 1'b1;   end
         OP_HALT:   begin uses_adder = 1'b0; do_halt = 1'b1;     end
         OP_NOP:    uses_adder = 1'b0;
         default:   uses_adder = 1'b0;
      endcase
   end

   assign sum = {1'b0, src} + {1'b0, imm};

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_RUN;
         pc       <= '0;
         reg_a    <= '0;
         reg_b    <= '0;
         out_port <= '0;
         carry    <= 1'b0;
         out_we   <= 1'b0;
      end else begin
         out_we <= 1'b0;
         if (retire) begin
            // Non-adder instructions clear C, matching the TD4 carry of 0 + Im.
            carry <= uses_adder ? sum[DATA_W] : 1'b0;
            if (wr_a) reg_a <= sum[DATA_W-1:0];
            if (wr_b) reg_b <= sum[DATA_W-1:0];
            if (wr_out) begin
               out_port <= sum[DATA_W-1:0];
               out_we   <= 1'b1;
            end
            pc <= take_jump ? jump_target : pc + ADDR_W'(1);
            if (do_halt) state <= ST_HALT;
         end
      end
   end

endmodule
